// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and types for the FIFO family (sync and async variants).
//   Holds the default parameter values and the pointer/count typedefs sized
//   for the default depth, plus the registered status-flag bundle.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DEPTH     = 256;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_PTR_SIZE  = 8;
  localparam int DEF_AF_LEVEL  = 252;
  localparam int DEF_AE_LEVEL  = 4;

  // One extra MSB on pointers separates the full and empty cases when the
  // address bits are equal; count needs the same width to reach DEPTH.
  typedef logic [DEF_PTR_SIZE:0] ptr_t;
  typedef logic [DEF_PTR_SIZE:0] count_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_flag_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_flag_ctrl
//   Owns the occupancy counter, the four status flags and the two
//   rejected-request pulses. Everything here is registered, so the flags
//   have no combinational path from the request inputs.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_ok, rd_ok    accepted write / accepted read this cycle
//   w_en, r_en      raw requests, used only to detect rejected requests
//   count           occupancy 0..DEPTH
//   full, empty     count == DEPTH / count == 0
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   write_error     pulse after a write rejected because the FIFO was full
//   read_error      pulse after a read rejected because the FIFO was empty
// ---------------------------------------------------------------------------
module fifo_flag_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PTR_SIZE = DEF_PTR_SIZE,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ok,
  input  logic              rd_ok,
  input  logic              w_en,
  input  logic              r_en,
  output logic [PTR_SIZE:0] count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              write_error,
  output logic              read_error
);

  localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0] AF_C    = (PTR_SIZE+1)'(AF_LEVEL);
  localparam logic [PTR_SIZE:0] AE_C    = (PTR_SIZE+1)'(AE_LEVEL);
  localparam logic [PTR_SIZE:0] ONE_C   = (PTR_SIZE+1)'(1);

  logic [PTR_SIZE:0] count_nxt;
  fifo_flags_t       flags;
  fifo_flags_t       flags_nxt;

  // A simultaneous accepted read and write leaves occupancy unchanged.
  function automatic logic [PTR_SIZE:0] next_count(input logic [PTR_SIZE:0] c,
                                                   input logic wr,
                                                   input logic rd);
    logic [PTR_SIZE:0] n;
    n = c;
    if (wr && !rd) n = c + ONE_C;
    else if (rd && !wr) n = c - ONE_C;
    return n;
  endfunction

  function automatic fifo_flags_t flags_of(input logic [PTR_SIZE:0] c);
    fifo_flags_t f;
    f.full         = (c == DEPTH_C);
    f.empty        = (c == '0);
    f.almost_full  = (c >= AF_C);
    f.almost_empty = (c <= AE_C);
    return f;
  endfunction

  always_comb begin
    count_nxt = next_count(count, wr_ok, rd_ok);
    flags_nxt = flags_of(count_nxt);
  end

  // Flags are computed from the next count so they update on the same edge
  // as count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      flags       <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      write_error <= 1'b0;
      read_error  <= 1'b0;
    end else begin
      count       <= count_nxt;
      flags       <= flags_nxt;
      write_error <= w_en && flags.full && !r_en;
      read_error  <= r_en && flags.empty;
    end
  end

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
//   Single-clock FIFO with registered status flags and error pulses.
//   Storage and read/write pointers live here; occupancy and flags are kept
//   by fifo_flag_ctrl.
//
//   Build option: define FIFO_FWFT_EN for first-word-fall-through, where
//   data_out continuously shows the head word and r_en pops it. Without
//   the macro, data_out is registered on each accepted read (latency 1)
//   and holds between reads.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   w_en, data_in  write request and data
//   r_en           read request
//   data_out       read data
//   full, empty, almost_full, almost_empty   registered status flags
//   count          occupancy 0..DEPTH
//   write_error    one-cycle pulse: write rejected (full, no read)
//   read_error     one-cycle pulse: read rejected (empty)
// ---------------------------------------------------------------------------
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int PTR_SIZE  = DEF_PTR_SIZE,
  parameter int AF_LEVEL  = DEF_AF_LEVEL,
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_SIZE:0]    count,
  output logic                 write_error,
  output logic                 read_error
);

  localparam logic [PTR_SIZE:0] PTR_ONE = (PTR_SIZE+1)'(1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_SIZE:0]    wptr;
  logic [PTR_SIZE:0]    rptr;
  logic                 wr_ok;
  logic                 rd_ok;

  // A full FIFO still accepts a write when a read frees a slot on the same
  // edge; full implies not empty, so that read is always accepted too.
  assign rd_ok = r_en && !empty;
  assign wr_ok = w_en && (!full || r_en);

  // Pointers wrap modulo 2*DEPTH; only the low bits address memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr[PTR_SIZE-1:0]] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; zero while empty (content is don't-care then).
  assign data_out = empty ? '0 : mem[rptr[PTR_SIZE-1:0]];
`else
  // Read register: captures the head word on an accepted read.
  always_ff @(posedge clk) begin
    if (rst) data_out <= '0;
    else if (rd_ok) data_out <= mem[rptr[PTR_SIZE-1:0]];
  end
`endif

  fifo_flag_ctrl #(
    .DEPTH    (DEPTH),
    .PTR_SIZE (PTR_SIZE),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_flag_ctrl (
    .clk          (clk),
    .rst          (rst),
    .wr_ok        (wr_ok),
    .rd_ok        (rd_ok),
    .w_en         (w_en),
    .r_en         (r_en),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .write_error  (write_error),
    .read_error   (read_error)
  );

endmodule

// File: tb/tb_sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_mem
//   Scoreboard bench for sync_fifo_mem at DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
//   The stimulus process drives one cycle at a time, keeps a queue model of
//   the FIFO contents, and pushes the expected post-edge state (plus extra
//   hand-written expectations at key points) into a scoreboard queue. A
//   monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       write_error;
  logic       read_error;

  always #5 clk = ~clk;

  sync_fifo_mem #(
    .DEPTH     (8),
    .DATA_SIZE (8),
    .PTR_SIZE  (3),
    .AF_LEVEL  (6),
    .AE_LEVEL  (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .write_error  (write_error),
    .read_error   (read_error)
  );

`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  localparam logic [6:0] M_CNT   = 7'h01;
  localparam logic [6:0] M_FULL  = 7'h02;
  localparam logic [6:0] M_EMPTY = 7'h04;
  localparam logic [6:0] M_AF    = 7'h08;
  localparam logic [6:0] M_AE    = 7'h10;
  localparam logic [6:0] M_ERR   = 7'h20;
  localparam logic [6:0] M_DOUT  = 7'h40;
  localparam logic [6:0] M_ALL   = 7'h7F;
  localparam logic [6:0] M_FLAGS = M_CNT | M_FULL | M_EMPTY | M_AF | M_AE | M_ERR;
  // Hand-written data_out values below assume registered (non-FWFT) reads.
  localparam logic [6:0] HD      = FWFT ? 7'h00 : M_DOUT;

  typedef struct {
    string      tag;
    logic [6:0] mask;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       we;
    logic       re;
    logic [7:0] dout;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_we;
  logic       m_re;
  string      cur_tag;
  int         checks = 0;
  int         errors = 0;

  task automatic cmp(input string tag, input string what,
                     input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
    end
  endtask

  // Monitor: compare everything queued for the edge just passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.mask[0]) cmp(e.tag, "count",        9'(count),        9'(e.cnt));
        if (e.mask[1]) cmp(e.tag, "full",         9'(full),         9'(e.full));
        if (e.mask[2]) cmp(e.tag, "empty",        9'(empty),        9'(e.empty));
        if (e.mask[3]) cmp(e.tag, "almost_full",  9'(almost_full),  9'(e.af));
        if (e.mask[4]) cmp(e.tag, "almost_empty", 9'(almost_empty), 9'(e.ae));
        if (e.mask[5]) begin
          cmp(e.tag, "write_error", 9'(write_error), 9'(e.we));
          cmp(e.tag, "read_error",  9'(read_error),  9'(e.re));
        end
        if (e.mask[6]) cmp(e.tag, "data_out", 9'(data_out), 9'(e.dout));
      end
    end
  end

  // One clock of stimulus; the model is advanced with the pre-edge state.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
    logic rd;
    logic wr;
    exp_t e;
    w_en    = w;
    r_en    = r;
    data_in = d;
    rst     = rs;
    if (rs) begin
      mq.delete();
      m_dout = 8'h00;
      m_we   = 1'b0;
      m_re   = 1'b0;
    end else begin
      rd   = r && (mq.size() != 0);
      wr   = w && ((mq.size() != 8) || r);
      m_we = w && (mq.size() == 8) && !r;
      m_re = r && (mq.size() == 0);
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    e.tag   = cur_tag;
    e.mask  = M_ALL;
    e.cnt   = 4'(mq.size());
    e.full  = (mq.size() == 8);
    e.empty = (mq.size() == 0);
    e.af    = (mq.size() >= 6);
    e.ae    = (mq.size() <= 1);
    e.we    = m_we;
    e.re    = m_re;
    if (FWFT) begin
      if (mq.size() != 0) e.dout = mq[0];
      else begin
        e.dout = 8'h00;
        e.mask = M_FLAGS;
      end
    end else begin
      e.dout = m_dout;
    end
    sb.push_back(e);
    w_en    = 1'b0;
    r_en    = 1'b0;
    rst     = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic hand(input string tag, input logic [6:0] mask, input logic [3:0] cnt,
                      input logic f, input logic em, input logic af, input logic ae,
                      input logic we, input logic re, input logic [7:0] dout);
    exp_t e;
    e.tag = tag; e.mask = mask; e.cnt = cnt; e.full = f; e.empty = em;
    e.af = af; e.ae = ae; e.we = we; e.re = re; e.dout = dout;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;

    cur_tag = "reset";
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    hand("reset_state", M_FLAGS | HD, 4'd0, 0, 1, 0, 1, 0, 0, 8'h00);

    cur_tag = "fill";
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
      if (i == 0) hand("ae_at1",   M_CNT | M_AE | M_EMPTY, 4'd1, 0, 0, 0, 1, 0, 0, 8'h00);
      if (i == 1) hand("ae_at2",   M_CNT | M_AE,           4'd2, 0, 0, 0, 0, 0, 0, 8'h00);
      if (i == 4) hand("af_at5",   M_CNT | M_AF,           4'd5, 0, 0, 0, 0, 0, 0, 8'h00);
      if (i == 5) hand("af_at6",   M_CNT | M_AF,           4'd6, 0, 0, 1, 0, 0, 0, 8'h00);
      if (i == 7) hand("full_at8", M_CNT | M_FULL,         4'd8, 1, 0, 1, 0, 0, 0, 8'h00);
    end

    cur_tag = "overflow";
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    hand("wr_err_pulse", M_CNT | M_FULL | M_ERR, 4'd8, 1, 0, 0, 0, 1, 0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    hand("wr_err_clear", M_ERR, 4'd8, 1, 0, 0, 0, 0, 0, 8'h00);

    cur_tag = "drain1";
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (i == 0) hand("first_rd", HD | M_CNT, 4'd7, 0, 0, 0, 0, 0, 0, 8'h11);
      if (i == 7) hand("last_rd",  HD | M_EMPTY | M_AE, 4'd0, 0, 1, 0, 1, 0, 0, 8'h18);
    end

    cur_tag = "refill";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h21 + i), 1'b0);
    cur_tag = "full_wr_rd";
    step(1'b1, 1'b1, 8'h55, 1'b0);
    hand("full_wr_rd", M_CNT | M_FULL | M_ERR | HD, 4'd8, 1, 0, 0, 0, 0, 0, 8'h21);
    cur_tag = "drain2";
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      if (i == 7) hand("last_is_55", HD | M_EMPTY, 4'd0, 0, 1, 0, 0, 0, 0, 8'h55);
    end

    cur_tag = "empty_rd";
    step(1'b0, 1'b1, 8'h00, 1'b0);
    hand("rd_err_pulse", M_CNT | M_EMPTY | M_ERR | HD, 4'd0, 0, 1, 0, 0, 0, 1, 8'h55);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    hand("rd_err_clear", M_ERR, 4'd0, 0, 0, 0, 0, 0, 0, 8'h00);
    cur_tag = "empty_wr_rd";
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    hand("empty_wr_rd", M_CNT | M_EMPTY | M_ERR | HD, 4'd1, 0, 0, 0, 0, 0, 1, 8'h55);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    hand("rd_3c", HD | M_EMPTY, 4'd0, 0, 1, 0, 0, 0, 0, 8'h3C);

    cur_tag = "gaps";
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00, 1'b0);
      if (i >= 3) begin
        step(1'b0, 1'b1, 8'h00, 1'b0);
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'h00, 1'b0);
      end
      if (i % 5 == 4) step(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
    end
    while (mq.size() != 0) step(1'b0, 1'b1, 8'h00, 1'b0);

    cur_tag = "rst_inflight";
    step(1'b1, 1'b0, 8'hE1, 1'b0);
    step(1'b1, 1'b0, 8'hE2, 1'b0);
    step(1'b1, 1'b0, 8'hE3, 1'b0);
    hand("three_in", M_CNT, 4'd3, 0, 0, 0, 0, 0, 0, 8'h00);
    step(1'b1, 1'b0, 8'h99, 1'b1);
    hand("rst_inflight", M_FLAGS | HD, 4'd0, 0, 1, 0, 1, 0, 0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    hand("wr_discarded", M_CNT | M_EMPTY, 4'd0, 0, 1, 0, 0, 0, 0, 8'h00);

    cur_tag = "first_word";
    step(1'b1, 1'b0, 8'h77, 1'b0);
`ifdef FIFO_FWFT_EN
    hand("fwft_visible", M_DOUT | M_EMPTY, 4'd1, 0, 0, 0, 0, 0, 0, 8'h77);
`else
    hand("no_bypass", M_DOUT | M_EMPTY, 4'd1, 0, 0, 0, 0, 0, 0, 8'h00);
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0);
    hand("rd_77", HD | M_CNT, 4'd0, 0, 0, 0, 0, 0, 0, 8'h77);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_mem.md
SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 Parameter DEPTH, default 256: number of entries; SHALL be a power of two, >= 4.
REQ-002 Parameter DATA_SIZE, default 8: word width in bits.
REQ-003 Parameter PTR_SIZE, default 8: address width; SHALL equal log2(DEPTH).
REQ-004 Parameter AF_LEVEL, default 252: almost_full threshold, 1..DEPTH-1.
REQ-005 Parameter AE_LEVEL, default 4: almost_empty threshold, 1..DEPTH-1, < AF_LEVEL.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 w_en  input  1  write request.
REQ-010 data_in  input  DATA_SIZE  write data.
REQ-011 r_en  input  1  read request.
REQ-012 data_out  output  DATA_SIZE  read data.
REQ-013 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-014 almost_full / almost_empty  output  1 each  threshold flags.
REQ-015 count  output  PTR_SIZE+1  current occupancy, 0..DEPTH.
REQ-016 write_error / read_error  output  1 each  one-cycle rejected-request pulses.

Function
REQ-017 Read acceptance: rd_ok = r_en && !empty.
REQ-018 Write acceptance: wr_ok = w_en && (!full || r_en); when full, simultaneous read frees a slot and the write SHALL be accepted.
REQ-019 On wr_ok: store data_in at wptr[PTR_SIZE-1:0]; wptr increments.
REQ-020 On rd_ok: rptr increments.
REQ-021 Pointers SHALL be PTR_SIZE+1-bit binary, wrapping modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-022 count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
REQ-023 full, empty, almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL) SHALL be registered, updating on the same edge as count; no combinational path from inputs.
REQ-024 write_error SHALL pulse 1 for one cycle after an edge where w_en && full && !r_en; memory, wptr and count unchanged.
REQ-025 read_error SHALL pulse 1 for one cycle after an edge where r_en && empty; rptr, count and data_out unchanged.
REQ-026 When empty, w_en && r_en: write accepted, read rejected, read_error pulses; the written word is not bypassed to data_out.
REQ-027 Default (non-FWFT) read: data_out SHALL register mem[rptr] on the rd_ok edge (latency 1) and hold otherwise.

Reset
REQ-028 With rst high at an edge: wptr, rptr and count = 0; empty = 1, almost_empty = 1; full = 0, almost_full = 0; write_error = 0, read_error = 0; data_out = 0.
REQ-029 Reset SHALL override w_en and r_en in the same cycle; an in-flight write is discarded.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro FIFO_FWFT_EN selects first-word-fall-through.
REQ-032 Defined: data_out SHALL continuously present mem[rptr[PTR_SIZE-1:0]] (zero read latency); r_en pops; a word written into an empty FIFO is visible the cycle after its write edge, together with empty = 0; data_out is don't-care while empty.
REQ-033 Undefined: REQ-027 behaviour; all other requirements unchanged in both modes.

Structure
REQ-034 Package fifo_pkg SHALL hold default parameter constants and the pointer/count typedefs shared with the async FIFO family.
REQ-035 Sub-module fifo_flag_ctrl SHALL own count and the four flags; storage and pointers stay in sync_fifo_mem.

Verification (DEPTH=8, PTR_SIZE=3, AF_LEVEL=6, AE_LEVEL=1)
REQ-036 Reset, then write 0x11..0x18 -> count 8, full=1, almost_full asserted from count 6; non-FWFT reads return 0x11..0x18 in order, each one cycle after r_en.
REQ-037 Full, w_en=1, r_en=0, data 0xAA -> write_error pulses one cycle; next 8 reads contain no 0xAA.
REQ-038 Full, w_en=r_en=1 with 0x55 -> count stays 8, no error; 0x55 is the last word read out.
REQ-039 Empty, r_en=1 -> read_error pulses, data_out unchanged; empty, w_en=r_en=1 with 0x3C -> read_error, count 1.
REQ-040 20 write/read pairs with random gaps -> pointers wrap twice, data order preserved, count never exceeds 8.
REQ-041 Write 3 words, assert rst with w_en=1 -> count 0, empty=1, almost_empty=1, data_out 0; FIFO_FWFT_EN build: first write 0x77 visible on data_out one cycle later without r_en.
